// File: rtl/fsk_nco_mod.sv
// fsk_nco_mod: M-ary FSK modulator. A phase accumulator (NCO) steps by a
// programmable per-tone increment, and a quarter-wave sine table turns the
// phase into signed samples. Symbols arrive on a valid/ready handshake and
// back-to-back symbols switch tone with no bubble and no phase jump.
// Optional build macro: FSK_PHASE_RESET_EN. When defined, the phase clears to
// 0 on every symbol accept (coherent FSK). When undefined, the phase is
// continuous across symbols and idle time (CPFSK).
module fsk_nco_mod #(
  parameter int OUT_W    = 16,
  parameter int PHASE_W  = 24,
  parameter int LUT_AW   = 6,
  parameter int SYM_BITS = 1,
  parameter int SPS      = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sym_valid,
  input  logic [SYM_BITS-1:0]        sym_data,
  output logic                       sym_ready,
  input  logic                       tone_wr,
  input  logic [SYM_BITS-1:0]        tone_addr,
  input  logic [PHASE_W-1:0]         tone_inc,
  output logic signed [OUT_W-1:0]    out,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int M     = 1 << SYM_BITS;
  localparam int Q     = 1 << (LUT_AW - 2);
  localparam int IDX_W = LUT_AW - 1;
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam longint PI_Q30 = 64'sd3373259426;
  localparam logic signed [OUT_W-1:0] PEAK = {1'b0, {(OUT_W-1){1'b1}}};

`ifdef FSK_PHASE_RESET_EN
  localparam bit PHASE_CLR = 1'b1;
`else
  localparam bit PHASE_CLR = 1'b0;
`endif

  // Quarter-wave table built at elaboration with an integer Taylor series
  // (Q30 fixed point), entry k = round(PEAK * sin(2*pi*k / 2^LUT_AW)).
  function automatic logic [Q*OUT_W-1:0] build_qtab();
    logic [Q*OUT_W-1:0] tab;
    longint x, x2, term, acc, amp, v;
    tab = '0;
    amp = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    for (int k = 0; k < Q; k++) begin
      x    = (PI_Q30 * 2 * longint'(k) + (64'sd1 <<< (LUT_AW - 1))) >>> LUT_AW;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
        term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
        acc  = acc + term;
      end
      v = (acc * amp + (64'sd1 <<< 29)) >>> 30;
      tab[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    return tab;
  endfunction

  localparam logic [Q*OUT_W-1:0] QTAB = build_qtab();

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [PHASE_W-1:0]       phase;
  logic [CNT_W-1:0]         cnt;
  logic [SYM_BITS-1:0]      cur_sym;
  logic [PHASE_W-1:0]       inc [M];
  logic signed [OUT_W-1:0]  tab_q;
  logic                     tab_valid;

  logic                     accept;
  logic                     last;
  logic [LUT_AW-1:0]        addr;
  logic [1:0]               quad;
  logic [LUT_AW-3:0]        qk;
  logic [IDX_W-1:0]         idx;
  logic signed [OUT_W-1:0]  mag;
  logic signed [OUT_W-1:0]  lut_val;

  assign accept = sym_valid && sym_ready;
  assign last   = (state == RUN) && (cnt == CNT_W'(SPS - 1));
  assign addr   = phase[PHASE_W-1 -: LUT_AW];
  assign quad   = addr[LUT_AW-1 -: 2];
  assign qk     = addr[LUT_AW-3:0];

  // Quarter-wave expansion: mirror the index on quadrants 1/3, negate on 2/3.
  // The mirrored index reaches Q only at the peak, which lies outside the table.
  always_comb begin
    // NOTE: every signal written here gets a value on every path so no latch is inferred.
    idx     = quad[0] ? (IDX_W'(Q) - {1'b0, qk}) : {1'b0, qk};
    mag     = idx[IDX_W-1] ? PEAK : QTAB[int'(idx[IDX_W-2:0]) * OUT_W +: OUT_W];
    lut_val = quad[1] ? -mag : mag;
  end

  // Tone frequency registers, written directly by the control port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a few plain flops rather than a RAM macro, so they carry reset values.
      for (int k = 0; k < M; k++) inc[k] <= PHASE_W'(k + 1) << (PHASE_W - LUT_AW);
    end else if (tone_wr) begin
      inc[tone_addr] <= tone_inc;
    end
  end

  // Symbol FSM with registered handshake/status outputs and the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      cnt       <= '0;
      cur_sym   <= '0;
      sym_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; every flop samples pre-edge values, and a later <= to the same flop overrides an earlier one.
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            cur_sym   <= sym_data;
            cnt       <= '0;
            busy      <= 1'b1;
            sym_ready <= 1'b0;
            if (PHASE_CLR) phase <= '0;
          end
        end
        RUN: begin
          phase <= phase + inc[cur_sym];
          if (last) begin
            cnt <= '0;
            if (accept) begin
              cur_sym   <= sym_data;
              sym_ready <= 1'b0;
              if (PHASE_CLR) phase <= '0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              sym_ready <= 1'b1;
            end
          end else begin
            cnt       <= cnt + 1'b1;
            sym_ready <= (cnt == CNT_W'(SPS - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output pipeline: table register then output register; zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tab_q     <= '0;
      tab_valid <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      tab_valid <= (state == RUN);
      tab_q     <= (state == RUN) ? lut_val : '0;
      out_valid <= tab_valid;
      out       <= tab_q;
    end
  end

endmodule

// File: tb/tb_fsk_nco_mod.sv
// tb_fsk_nco_mod: scoreboard bench for fsk_nco_mod. A reference model turns
// accepted symbols and tone writes into expected samples computed with real
// sine arithmetic; a monitor pops and compares whenever out_valid is high.
// Honours FSK_PHASE_RESET_EN the same way the design does.
module tb_fsk_nco_mod;

  localparam int OUT_W    = 16;
  localparam int PHASE_W  = 24;
  localparam int LUT_AW   = 6;
  localparam int SYM_BITS = 1;
  localparam int SPS      = 64;
  localparam int M        = 1 << SYM_BITS;
  localparam int PT_SHIFT = PHASE_W - LUT_AW;
  localparam int NPTS     = 1 << LUT_AW;
  localparam real PI      = 3.14159265358979323846;
  localparam real AMP     = 32767.0;

`ifdef FSK_PHASE_RESET_EN
  localparam bit COHERENT = 1'b1;
`else
  localparam bit COHERENT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sym_valid = 1'b0;
  logic [SYM_BITS-1:0] sym_data = '0;
  logic tone_wr = 1'b0;
  logic [SYM_BITS-1:0] tone_addr = '0;
  logic [PHASE_W-1:0] tone_inc = '0;
  logic sym_ready, out_valid, busy;
  logic signed [OUT_W-1:0] out;

  fsk_nco_mod #(.OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW),
                .SYM_BITS(SYM_BITS), .SPS(SPS)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .tone_wr(tone_wr), .tone_addr(tone_addr),
    .tone_inc(tone_inc), .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Ideal sample for a table point: round(AMP * sin(2*pi*pts/NPTS)).
  function automatic logic signed [OUT_W-1:0] ref_pts(input int pts);
    real v;
    int  r;
    v = AMP * $sin(2.0 * PI * real'(pts % NPTS) / real'(NPTS));
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return r[OUT_W-1:0];
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic signed [OUT_W-1:0] val; int cyc; } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int m_left = 0;                 // samples still owed by the current symbol
  bit m_ready = 1'b1;
  logic [SYM_BITS-1:0] m_sym;
  logic [PHASE_W-1:0] m_phase;
  logic [PHASE_W-1:0] m_inc [M];

  // Each edge: a running symbol emits the sample of its current phase, then
  // advances; an offered symbol is taken when one is not in progress or on
  // its last sample; a tone write lands after this edge's step.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_left  = 0;
      m_ready = 1'b1;
      m_sym   = '0;
      m_phase = '0;
      for (int k = 0; k < M; k++) m_inc[k] = PHASE_W'(k + 1) << PT_SHIFT;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_left > 0) begin
        exp_q.push_back('{ref_pts(int'(m_phase >> PT_SHIFT)), cyc - 1});
        m_phase = m_phase + m_inc[m_sym];
        m_left--;
      end
      if (sym_valid && m_ready) begin
        m_sym  = sym_data;
        m_left = SPS;
        if (COHERENT) m_phase = '0;
      end
      if (tone_wr) m_inc[tone_addr] = tone_inc;
      m_ready = (m_left <= 1);
    end
  end

  // ---------------- monitor ----------------
  logic signed [OUT_W-1:0] obs[$];
  int run_len = 0;
  int max_run = 0;
  exp_t e;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("sym_ready", sym_ready, m_ready);
      check("busy", busy, m_left > 0);
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        obs.push_back(out);
        if (exp_q.size() == 0) flag_fail("unexpected sample");
        else begin
          e = exp_q.pop_front();
          check("sample", out, e.val);
          check("latency", cyc - e.cyc, 2);
        end
      end else begin
        run_len = 0;
        check("idle out", out, 0);
        if (exp_q.size() > 0 && (cyc - exp_q[0].cyc) >= 2) begin
          flag_fail("sample missing");
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic signed [OUT_W-1:0] obs_at(input int i);
    return (i < obs.size()) ? obs[i] : 'x;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_sym(input logic [SYM_BITS-1:0] s, input bit hold);
    int t;
    t = 0;
    sym_valid = 1'b1;
    sym_data  = s;
    @(negedge clk);
    while (!sym_ready && t < 3 * SPS) begin
      @(negedge clk);
      t++;
    end
    if (!sym_ready) flag_fail("handshake timeout");
    @(posedge clk);
    #1;
    if (!hold) sym_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || out_valid) && t < 6 * SPS) begin
      @(negedge clk);
      t++;
    end
    if (busy || out_valid) flag_fail("idle timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic tone_pulse(input logic [SYM_BITS-1:0] a, input logic [PHASE_W-1:0] v);
    tone_wr   = 1'b1;
    tone_addr = a;
    tone_inc  = v;
    @(posedge clk);
    #1;
    tone_wr = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  int start;
  bit hold;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset out", out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset sym_ready", sym_ready, 1);
    @(posedge clk);
    #1;

    // One symbol of tone 0: one full cycle over 64 samples.
    obs.delete();
    send_sym(0, 0);
    wait_idle();
    check("s0 length", obs.size(), SPS);
    check("s0 first", obs_at(0), 0);
    check("s0 sample16", obs_at(16), 32767);
    check("s0 sample48", obs_at(48), -32767);
    check("s0 idle out", out, 0);

    // Tone 1: two cycles per symbol.
    obs.delete();
    send_sym(1, 0);
    wait_idle();
    check("s1 length", obs.size(), SPS);
    check("s1 sample8", obs_at(8), 32767);

    // Back-to-back 0,1,0 with valid held: one contiguous burst.
    obs.delete();
    max_run = 0;
    send_sym(0, 1);
    send_sym(1, 1);
    send_sym(0, 0);
    wait_idle();
    check("b2b contiguous", max_run, 3 * SPS);
    check("b2b length", obs.size(), 3 * SPS);

    // Retune tone 1 to 4 points/clock while it plays, at cnt=10.
    obs.delete();
    send_sym(1, 0);
    repeat (10) @(posedge clk);
    #1;
    tone_pulse(1, PHASE_W'(4) << PT_SHIFT);
    wait_idle();
    check("retune sample11", obs_at(11), ref_pts(22));
    check("retune sample12", obs_at(12), ref_pts(26));
    check("retune sample13", obs_at(13), ref_pts(30));

    // Tone 0 rate unaffected; continuous phase picks up at point 42.
    start = COHERENT ? 0 : 42;
    obs.delete();
    send_sym(0, 0);
    wait_idle();
    check("tone0 sample1", obs_at(1), ref_pts(start + 1));
    check("tone0 sample2", obs_at(2), ref_pts(start + 2));

    // Symbol 1 then 0: first sample of each depends on phase mode.
    obs.delete();
    send_sym(1, 1);
    send_sym(0, 0);
    wait_idle();
    check("pair first", obs_at(0), ref_pts(start));
    check("pair second first", obs_at(SPS), ref_pts(start));
    tone_pulse(1, PHASE_W'(2) << PT_SHIFT);

    // Tone write on the same edge as accept: new value applies.
    obs.delete();
    tone_wr   = 1'b1;
    tone_addr = 0;
    tone_inc  = PHASE_W'(3) << PT_SHIFT;
    send_sym(0, 0);
    tone_wr = 1'b0;
    wait_idle();
    check("wr+accept sample1", obs_at(1), ref_pts(start + 3));
    tone_pulse(0, PHASE_W'(1) << PT_SHIFT);

    // Asynchronous reset mid-symbol at cnt=30.
    send_sym(1, 0);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort out", out, 0);
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort sym_ready", sym_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    obs.delete();
    send_sym(0, 0);
    wait_idle();
    check("post-reset length", obs.size(), SPS);
    check("post-reset first", obs_at(0), 0);
    check("post-reset sample16", obs_at(16), 32767);

    // Random symbols, gaps and tone writes, checked by the scoreboard.
    for (int i = 0; i < 40; i++) begin
      hold = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0)
        tone_pulse(SYM_BITS'($urandom_range(M - 1, 0)), PHASE_W'($urandom()));
      send_sym(SYM_BITS'($urandom_range(M - 1, 0)), hold);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(SPS - 3, 1)) @(posedge clk);
        #1;
        tone_pulse(SYM_BITS'($urandom_range(M - 1, 0)), PHASE_W'($urandom()));
      end
      if (!hold) begin
        repeat ($urandom_range(4, 0)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    sym_valid = 1'b0;
    wait_idle();
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
